// File: rtl/stream_out_fifo128_if.sv
`timescale 1ns/1ps
// Kernel-result / host-output stream bundle for stream_out_fifo128.
// Carries the inbound (s1i_*) and outbound (s1o_*) valid/ready/data groups.
// slave = the FIFO side, master = the side driving kernel words and consuming host words.
interface stream_out_fifo128_if #(
    parameter int DW = 128
);
    logic          s1i_valid;
    logic          s1i_rdy;
    logic [DW-1:0] s1i_data;
    logic          s1o_valid;
    logic          s1o_rdy;
    logic [DW-1:0] s1o_data;

    modport slave (
        input  s1i_valid,
        input  s1i_data,
        output s1i_rdy,
        output s1o_valid,
        output s1o_data,
        input  s1o_rdy
    );

    modport master (
        output s1i_valid,
        output s1i_data,
        input  s1i_rdy,
        input  s1o_valid,
        input  s1o_data,
        output s1o_rdy
    );
endinterface

// File: rtl/stream_out_fifo128.sv
`timescale 1ns/1ps
// Purpose: first-word-fall-through FIFO buffering 128-bit kernel results toward the host stream.
// Latency: a word written into an empty FIFO is visible on s1o_* one cycle after the write edge.
// Backpressure: s1i_rdy drops at level == DEPTH; it is built from registered state only.
//
// Ports:
//   clk, rst         - sole clock (rising edge), asynchronous active-low reset
//   bus (slave)      - s1i_valid/s1i_rdy/s1i_data in, s1o_valid/s1o_rdy/s1o_data out
//   level            - occupancy 0..DEPTH
//   almost_full      - level >= AFULL_THRESH
//   words_out        - words delivered to the host (statistics build only, else 0)
//   stall_cycles     - cycles with s1i_valid=1 and s1i_rdy=0 (statistics build only, else 0)
//
// Build option: define STREAM_FIFO_STATS_EN to build the words_out / stall_cycles counters.
// Without it the counter registers are not built and both ports read 0.
module stream_out_fifo128 #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_out_fifo128_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic [31:0]              words_out,
    output logic [31:0]              stall_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage is deliberately left out of reset: only pointers and level decide
    // what is valid, so stale contents are never observable.
    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_in_rdy;
    logic w_out_vld;
    logic w_wr;
    logic w_rd;

    // Both handshakes look only at registered level; a read at full therefore
    // cannot open the input in the same cycle, which keeps s1o_rdy off the
    // s1i_rdy timing path.
    assign w_in_rdy  = (r_level != LW'(DEPTH));
    assign w_out_vld = (r_level != '0);
    assign w_wr      = bus.s1i_valid && w_in_rdy;
    assign w_rd      = w_out_vld && bus.s1o_rdy;

    assign bus.s1i_rdy   = w_in_rdy;
    assign bus.s1o_valid = w_out_vld;
    assign bus.s1o_data  = r_mem[r_rd_ptr];

    assign level       = r_level;
    assign almost_full = (r_level >= LW'(AFULL_THRESH));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.s1i_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap DEPTH-1 -> 0 is the natural
    // AW-bit rollover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef STREAM_FIFO_STATS_EN
    logic [31:0] r_words_out;
    logic [31:0] r_stall_cycles;

    // Both counters wrap silently at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_words_out    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_rd) begin
                r_words_out <= r_words_out + 32'd1;
            end
            if (bus.s1i_valid && !w_in_rdy) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign words_out    = r_words_out;
    assign stall_cycles = r_stall_cycles;
`else
    assign words_out    = 32'd0;
    assign stall_cycles = 32'd0;
`endif

endmodule
